// File: rtl/aes_key_mem_mc_pkg.sv
// Shared AES key-schedule constants: key length codes, Nk/Nr lookup, Rcon table
// and the word-store write request format.
package aes_key_mem_mc_pkg;

  typedef enum logic [1:0] {KL_128 = 2'd0, KL_192 = 2'd1, KL_256 = 2'd2, KL_BAD = 2'd3} keylen_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GEN} state_e;

  localparam int MAX_WORDS = 60;

  // Up to 8 consecutive words starting at base; word k sits in data[7-k].
  typedef struct packed {
    logic            en;
    logic [5:0]      base;
    logic [3:0]      num;
    logic [7:0][31:0] data;
  } wr_req_t;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [5:0] last_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return 6'd51;
      KL_256:  return 6'd59;
      default: return 6'd43;
    endcase
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_mem_mc_store.sv
// Per-context round-key word storage with a multi-word write port, a registered
// 4-word read port and the stored key length code of each context.
module aes_key_mem_mc_store
  import aes_key_mem_mc_pkg::*;
#(
  parameter int NUM_CTX = 4,
  parameter int CTX_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CTX_W-1:0] wr_ctx,
  input  wr_req_t          wr,
  input  logic             kl_we,
  input  logic [CTX_W-1:0] kl_ctx,
  input  logic [1:0]       kl_val,
  input  logic [CTX_W-1:0] rd_ctx,
  input  logic [3:0]       rd_round,
  output logic [127:0]     rd_data
);

  logic [31:0]             mem_q [NUM_CTX][MAX_WORDS];
  logic [NUM_CTX-1:0][1:0] klen_q;
  logic [127:0]            rd_data_q;
  logic [5:0]              rd_base;
  logic                    rd_ok;

  assign rd_base = {rd_round, 2'b00};
  assign rd_ok   = (int'(rd_ctx) < NUM_CTX) && (rd_round <= nr_of(klen_q[rd_ctx]));
  assign rd_data = rd_data_q;

  // Word storage is never reset; stale words are masked by the keylen check.
  always_ff @(posedge clk) begin
    if (wr.en) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(wr.num)) mem_q[wr_ctx][wr.base + 6'(k)] <= wr.data[7-k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      klen_q    <= '0;
      rd_data_q <= '0;
    end else begin
      if (kl_we) klen_q[kl_ctx] <= kl_val;
      rd_data_q <= rd_ok ? {mem_q[rd_ctx][rd_base],         mem_q[rd_ctx][rd_base + 6'd1],
                            mem_q[rd_ctx][rd_base + 6'd2],  mem_q[rd_ctx][rd_base + 6'd3]}
                         : '0;
    end
  end

endmodule

// File: rtl/aes_key_mem_mc.sv
// Multi-context AES key expansion: one word per cycle into a shared store,
// with an external S-box and per-context ready flags.
module aes_key_mem_mc
  import aes_key_mem_mc_pkg::*;
#(
  parameter int NUM_CTX = 4,
  parameter int CTX_W   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [255:0]       key,
  input  logic [1:0]         keylen,
  input  logic               init,
  input  logic [CTX_W-1:0]   init_ctx,
  output logic               init_reject,
  output logic               busy,
  output logic [NUM_CTX-1:0] ctx_ready,
  input  logic [CTX_W-1:0]   rd_ctx,
  input  logic [3:0]         round,
  output logic [127:0]       round_key,
  output logic [31:0]        sboxw,
  input  logic [31:0]        new_sboxw
);

  state_e             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [2:0]         pos_q, pos_d;
  logic [3:0]         rc_q, rc_d;
  logic [CTX_W-1:0]   ctx_q, ctx_d;
  logic [1:0]         klen_q, klen_d;
  logic [7:0][31:0]   win_q, win_d;
  logic [NUM_CTX-1:0] ready_q, ready_d;
  logic               rej_q, rej_d;

  logic               accept;
  logic [3:0]         nk;
  logic [8:0]         sh_in, sh_q;
  logic [31:0]        prev, t, new_w;
  wr_req_t            wr;

  // win_q[0] is w[i-1], win_q[k] is w[i-1-k]; the key is right-aligned on load.
  assign nk     = nk_of(klen_q);
  assign sh_in  = {4'd8 - nk_of(keylen), 5'b0};
  assign sh_q   = {4'd8 - nk, 5'b0};
  assign prev   = win_q[0];
  assign accept = init && (keylen != KL_BAD) && (int'(init_ctx) < NUM_CTX) && (state_q == S_IDLE);
  assign sboxw  = (pos_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    rc_d    = rc_q;
    ctx_d   = ctx_q;
    klen_d  = klen_q;
    win_d   = win_q;
    ready_d = ready_q;
    rej_d   = init && !accept;
    wr      = '0;
    t       = prev;
    if (pos_q == 3'd0)                      t = new_sboxw ^ {rcon_of(rc_q), 24'h0};
    else if (nk == 4'd8 && pos_q == 3'd4)   t = new_sboxw;
    new_w = win_q[3'(nk - 4'd1)] ^ t;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d           = S_LOAD;
          ctx_d             = init_ctx;
          klen_d            = keylen;
          win_d             = key >> sh_in;
          ready_d[init_ctx] = 1'b0;
        end
      end
      S_LOAD: begin
        wr.en   = 1'b1;
        wr.base = 6'd0;
        wr.num  = nk;
        wr.data = win_q << sh_q;
        idx_d   = {2'b00, nk};
        pos_d   = 3'd0;
        rc_d    = 4'd1;
        state_d = S_GEN;
      end
      S_GEN: begin
        wr.en   = 1'b1;
        wr.base = idx_q;
        wr.num  = 4'd1;
        wr.data = {new_w, 224'h0};
        win_d   = {win_q[6:0], new_w};
        idx_d   = idx_q + 6'd1;
        pos_d   = (pos_q == 3'(nk - 4'd1)) ? 3'd0 : pos_q + 3'd1;
        if (pos_q == 3'd0) rc_d = rc_q + 4'd1;
        if (idx_q == last_of(klen_q)) begin
          state_d        = S_IDLE;
          ready_d[ctx_q] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pos_q   <= '0;
      rc_q    <= '0;
      ctx_q   <= '0;
      klen_q  <= '0;
      win_q   <= '0;
      ready_q <= '0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      rc_q    <= rc_d;
      ctx_q   <= ctx_d;
      klen_q  <= klen_d;
      win_q   <= win_d;
      ready_q <= ready_d;
      rej_q   <= rej_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign ctx_ready   = ready_q;
  assign init_reject = rej_q;

  aes_key_mem_mc_store #(.NUM_CTX(NUM_CTX), .CTX_W(CTX_W)) u_store (
    .clk      (clk),
    .reset    (reset),
    .wr_ctx   (ctx_q),
    .wr       (wr),
    .kl_we    (accept),
    .kl_ctx   (init_ctx),
    .kl_val   (keylen),
    .rd_ctx   (rd_ctx),
    .rd_round (round),
    .rd_data  (round_key)
  );

endmodule

// File: tb/tb_aes_key_mem_mc.sv
// Bench for aes_key_mem_mc: FIPS-197 key-expansion model with a per-word store
// model checked every cycle, plus directed known-answer vectors.
module tb_aes_key_mem_mc;

  localparam int NUM_CTX = 4;
  localparam int CTX_W   = 2;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [255:0]       key = '0;
  logic [1:0]         keylen = '0;
  logic               init = 1'b0;
  logic [CTX_W-1:0]   init_ctx = '0;
  logic [CTX_W-1:0]   rd_ctx = '0;
  logic [3:0]         round = '0;
  logic               init_reject, busy;
  logic [NUM_CTX-1:0] ctx_ready;
  logic [127:0]       round_key;
  logic [31:0]        sboxw, new_sboxw;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sbox_t [256];
  logic [31:0] xw [60];

  // model state
  logic [31:0]        m_mem   [NUM_CTX][60];
  bit                 m_known [NUM_CTX][60];
  int                 m_klen  [NUM_CTX];
  logic [NUM_CTX-1:0] m_ready = '0;
  logic [31:0]        m_pend  [60];
  bit                 m_active = 1'b0;
  int                 m_t = 0, m_ctx = 0, m_nk = 4, m_nr = 10;
  logic               exp_rej = 1'b0;
  logic [127:0]       exp_rk = '0;
  bit                 rk_known = 1'b1;

  aes_key_mem_mc #(.NUM_CTX(NUM_CTX), .CTX_W(CTX_W)) dut (
    .clk(clk), .reset(reset), .key(key), .keylen(keylen), .init(init), .init_ctx(init_ctx),
    .init_reject(init_reject), .busy(busy), .ctx_ready(ctx_ready), .rd_ctx(rd_ctx),
    .round(round), .round_key(round_key), .sboxw(sboxw), .new_sboxw(new_sboxw)
  );

  always #5 clk = ~clk;

  assign new_sboxw = {sbox_t[sboxw[31:24]], sbox_t[sboxw[23:16]], sbox_t[sboxw[15:8]], sbox_t[sboxw[7:0]]};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from the GF(2^8) inverse followed by the affine transform
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h0;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < n; j++) r = xtime(r);
    return r;
  endfunction

  task automatic expand(input logic [255:0] k, input int kl);
    int nk, nr;
    logic [31:0] tw;
    nk = 4 + 2 * kl;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) xw[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tw = xw[i-1];
      if (i % nk == 0)                tw = subw({tw[23:0], tw[31:24]}) ^ {rcon(i / nk), 24'h0};
      else if (nk == 8 && i % 8 == 4) tw = subw(tw);
      xw[i] = xw[i-nk] ^ tw;
    end
  endtask

  task automatic model_step();
    int wi, nrr, ci;
    bit acc;
    if (reset) begin
      m_active = 1'b0;
      m_ready  = '0;
      for (int c = 0; c < NUM_CTX; c++) m_klen[c] = 0;
      exp_rej  = 1'b0;
      exp_rk   = '0;
      rk_known = 1'b1;
      return;
    end
    // registered read sees the store contents from before this edge
    ci = int'(rd_ctx);
    rk_known = 1'b1;
    exp_rk = '0;
    if (ci < NUM_CTX) begin
      nrr = 10 + 2 * m_klen[ci];
      if (int'(round) <= nrr) begin
        for (int j = 0; j < 4; j++) begin
          wi = 4 * int'(round) + j;
          if (!m_known[ci][wi]) rk_known = 1'b0;
          else exp_rk[127 - 32*j -: 32] = m_mem[ci][wi];
        end
      end
    end
    acc = init && (keylen != 2'd3) && (int'(init_ctx) < NUM_CTX) && !m_active;
    exp_rej = init && !acc;
    if (m_active) begin
      m_t++;
      if (m_t == 1) begin
        for (int j = 0; j < m_nk; j++) begin
          m_mem[m_ctx][j] = m_pend[j];
          m_known[m_ctx][j] = 1'b1;
        end
      end else begin
        wi = m_nk + m_t - 2;
        m_mem[m_ctx][wi] = m_pend[wi];
        m_known[m_ctx][wi] = 1'b1;
        if (wi == 4 * (m_nr + 1) - 1) begin
          m_ready[m_ctx] = 1'b1;
          m_active = 1'b0;
        end
      end
    end
    if (acc) begin
      expand(key, int'(keylen));
      for (int j = 0; j < 60; j++) m_pend[j] = xw[j];
      m_ctx = int'(init_ctx);
      m_nk = 4 + 2 * int'(keylen);
      m_nr = m_nk + 6;
      m_klen[m_ctx] = int'(keylen);
      m_ready[m_ctx] = 1'b0;
      m_active = 1'b1;
      m_t = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #2;
    chk("busy", 128'(busy), 128'(m_active));
    chk("ctx_ready", 128'(ctx_ready), 128'(m_ready));
    chk("init_reject", 128'(init_reject), 128'(exp_rej));
    if (rk_known) chk("round_key", round_key, exp_rk);
  end

  task automatic wait_ready(input int c, input int start, input int exp_e, input string nm);
    int e;
    e = -1;
    for (int n = start; n <= 90; n++) begin
      @(posedge clk);
      #2;
      if (ctx_ready[c]) begin
        e = n;
        break;
      end
    end
    chk(nm, 128'(e), 128'(exp_e));
  endtask

  task automatic do_init(input logic [1:0] kl, input int c, input logic [255:0] k,
                         input int exp_e, input string nm);
    @(negedge clk);
    key = k; keylen = kl; init_ctx = CTX_W'(c); init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    wait_ready(c, 1, exp_e, nm);
  endtask

  task automatic rd(input int c, input int r, input logic [127:0] exp, input string nm);
    @(negedge clk);
    rd_ctx = CTX_W'(c); round = 4'(r);
    @(posedge clk);
    #2;
    chk(nm, round_key, exp);
  endtask

  initial begin
    build_sbox();
    expand(K128, 0);
    chk("model_aes128_w40", 128'(xw[40]), 128'hd014f9a8);
    expand(K256, 2);
    chk("model_aes256_w59", 128'(xw[59]), 128'h6d68de36);

    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_ready", 128'(ctx_ready), 128'h0);
    chk("rst_reject", 128'(init_reject), 128'h0);
    chk("rst_round_key", round_key, 128'h0);
    reset = 1'b0;

    do_init(2'd0, 0, K128, 41, "aes128_ready_edge");
    rd(0, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c, "aes128_r0");
    rd(0, 1, 128'ha0fafe1788542cb123a339392a6c7605, "aes128_r1");
    rd(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_r10");
    rd(0, 11, 128'h0, "aes128_r11_zero");

    do_init(2'd1, 1, K192, 47, "aes192_ready_edge");
    rd(1, 12, 128'he98ba06f448c773c8ecc720401002202, "aes192_r12");
    rd(1, 13, 128'h0, "aes192_r13_zero");

    @(negedge clk);
    rd_ctx = 2'd0; round = 4'd10;
    do_init(2'd2, 2, K256, 53, "aes256_ready_edge");
    rd(2, 2, 128'ha573c29fa176c498a97fce93a572c09c, "aes256_r2");
    rd(2, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "aes256_r14");
    rd(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "ctx0_r10_kept");

    // illegal key length is rejected and changes nothing
    @(negedge clk);
    key = K128; keylen = 2'd3; init_ctx = 2'd3; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("kl3_reject", 128'(init_reject), 128'h1);
    chk("kl3_not_busy", 128'(busy), 128'h0);
    @(negedge clk);
    chk("kl3_reject_pulse", 128'(init_reject), 128'h0);
    chk("kl3_ready_kept", 128'(ctx_ready), 128'h7);

    // init while busy is rejected; the running expansion and its timing hold
    @(negedge clk);
    rd_ctx = 2'd3; round = 4'd1;
    key = K128; keylen = 2'd0; init_ctx = 2'd3; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (4) @(negedge clk);
    key = K256; keylen = 2'd2; init_ctx = 2'd0; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("busy_reject", 128'(init_reject), 128'h1);
    @(negedge clk);
    chk("busy_reject_pulse", 128'(init_reject), 128'h0);
    wait_ready(3, 7, 41, "ctx3_ready_edge");
    chk("ctx0_ready_kept", 128'(ctx_ready[0]), 128'h1);
    rd(3, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "ctx3_r10");

    // reset in the middle of an AES-256 expansion
    @(negedge clk);
    rd_ctx = 2'd0; round = 4'd10;
    key = K256; keylen = 2'd2; init_ctx = 2'd1; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 128'(busy), 128'h0);
    chk("abort_ready", 128'(ctx_ready), 128'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(1, 11, 128'h0, "abort_ctx1_r11_zero");
    do_init(2'd0, 0, K128, 41, "post_reset_ready_edge");
    rd(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "post_reset_r10");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
